// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op encodings, flag struct and bitwise evaluator for gate_alu_pipe
//
// Contents:
//   GATE_MAX_W  widest operand gate_eval handles. Callers zero-extend to this width and slice.
//   gate_op_t   3-bit operation select.
//   OP_*        operation encodings.
//   gate_flag_t reduction flags carried alongside a result.
//   gate_eval   bitwise evaluation of one operation.

package gate_pkg;

  localparam int GATE_MAX_W = 64;

  typedef logic [2:0] gate_op_t;

  localparam gate_op_t OP_AND  = 3'd0;
  localparam gate_op_t OP_OR   = 3'd1;
  localparam gate_op_t OP_NAND = 3'd2;
  localparam gate_op_t OP_NOR  = 3'd3;
  localparam gate_op_t OP_XOR  = 3'd4;
  localparam gate_op_t OP_XNOR = 3'd5;
  localparam gate_op_t OP_NOT  = 3'd6;
  localparam gate_op_t OP_PASS = 3'd7;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } gate_flag_t;

  // Every operation is purely bitwise. A caller can therefore evaluate at
  // GATE_MAX_W and keep only its low WIDTH bits. The padding bits never
  // influence the kept ones.
  function automatic logic [GATE_MAX_W-1:0] gate_eval(
    input gate_op_t                op,
    input logic [GATE_MAX_W-1:0]   a,
    input logic [GATE_MAX_W-1:0]   b
  );
    logic [GATE_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// rtl/gate_pipe_stage.sv - single valid/ready register slice with generic payload
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_data   [W-1:0]     payload captured on upstream handshake
//   out_valid / out_ready downstream handshake
//   out_data  [W-1:0]     registered payload
//
// in_ready is combinational from out_ready. A full slice can therefore take a new
// beat in the same cycle its current beat leaves. This is what lets chained
// slices run at one beat per cycle.

module gate_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gate_alu_pipe.sv
// rtl/gate_alu_pipe.sv - two-stage valid/ready bitwise logic unit with reduction flags and result counter
//
// Parameters:
//   WIDTH  operand/result width, 1..GATE_MAX_W
//   CNT_W  completed-result counter width
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           operand handshake
//   in_op[2:0], in_a, in_b      operation select and operands
//   out_valid/out_ready         result handshake
//   out_y                       result
//   out_zero/out_ones/out_parity reduction flags of out_y
//   out_cnt                     results accepted by the consumer, wrapping

module gate_alu_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int P1_W = 3 + 2 * WIDTH;
  localparam int P2_W = WIDTH + 3;

  logic              s1_v;
  logic              s2_rdy;
  logic [P1_W-1:0]   s1_data;
  logic [P2_W-1:0]   s2_in;
  logic [P2_W-1:0]   s2_data;

  gate_op_t          s1_op;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;

  logic [GATE_MAX_W-1:0] a_ext;
  logic [GATE_MAX_W-1:0] b_ext;
  logic [GATE_MAX_W-1:0] eval_full;
  logic [WIDTH-1:0]      y_comb;
  gate_flag_t            flag_comb;
  gate_flag_t            flag_q;
  logic                  unused_eval_hi;

  // Stage 1 holds the raw operands. The evaluation sits between the stages, so
  // no path runs from in_* to out_*.
  gate_pipe_stage #(.W(P1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_op, in_a, in_b}),
    .out_valid (s1_v),
    .out_ready (s2_rdy),
    .out_data  (s1_data)
  );

  assign s1_op = s1_data[P1_W-1 -: 3];
  assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_b  = s1_data[WIDTH-1:0];

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = s1_a;
    b_ext[WIDTH-1:0] = s1_b;
    eval_full        = gate_eval(s1_op, a_ext, b_ext);
    y_comb           = eval_full[WIDTH-1:0];
    flag_comb.zero   = (y_comb == '0);
    flag_comb.ones   = (y_comb == '1);
    flag_comb.parity = ^y_comb;
  end

  // Padding bits of the wide evaluation are deliberately discarded.
  assign unused_eval_hi = ^eval_full;

  assign s2_in = {y_comb, flag_comb};

  gate_pipe_stage #(.W(P2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_ready  (s2_rdy),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_y      = s2_data[P2_W-1 -: WIDTH];
  assign flag_q     = s2_data[2:0];
  assign out_zero   = flag_q.zero;
  assign out_ones   = flag_q.ones;
  assign out_parity = flag_q.parity;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_alu_pipe.sv
// tb/tb_gate_alu_pipe.sv - directed self-checking bench for gate_alu_pipe

module tb_gate_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_y;
  logic        out_zero;
  logic        out_ones;
  logic        out_parity;
  logic [15:0] out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gate_alu_pipe #(.WIDTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_zero   (out_zero),
    .out_ones   (out_ones),
    .out_parity (out_parity),
    .out_cnt    (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_op = 3'd7; in_a = 4'hF; in_b = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_cnt !== 16'd0) begin
        n_fail++; $display("FAIL reset_valid_cnt: out_valid=%b out_cnt=%0d required 0 0", out_valid, out_cnt);
      end
      n_checks++;
      if ({out_zero, out_ones, out_parity} !== 3'b000 || out_y !== 4'h0) begin
        n_fail++; $display("FAIL reset_flags: flags=%b y=%h required 000 0", {out_zero, out_ones, out_parity}, out_y);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_ignored_input: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [3:0] exp_y [8];
    logic [7:0] exp_zero;
    logic [7:0] exp_ones;
    exp_y = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0101, 4'b1010};
    exp_zero = 8'b0010_1001;
    exp_ones = 8'b0001_0110;
    do_reset();
    out_ready = 1'b1; in_a = 4'b1010; in_b = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      in_op = 3'(c);
      tick();
      n_checks++;
      if (out_valid !== (c >= 1 && c <= 8)) begin
        n_fail++; $display("FAIL sweep_valid c=%0d: got %b required %b", c, out_valid, (c >= 1 && c <= 8));
      end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if (out_y !== exp_y[c-1]) begin
          n_fail++; $display("FAIL sweep_y op=%0d: got %b required %b", c-1, out_y, exp_y[c-1]);
        end
        n_checks++;
        if (out_zero !== exp_zero[c-1] || out_ones !== exp_ones[c-1] || out_parity !== 1'b0) begin
          n_fail++; $display("FAIL sweep_flags op=%0d: zop=%b%b%b required %b%b0", c-1,
                             out_zero, out_ones, out_parity, exp_zero[c-1], exp_ones[c-1]);
        end
      end
    end
    n_checks++;
    if (out_cnt !== 16'd8) begin
      n_fail++; $display("FAIL sweep_cnt: got %0d required 8", out_cnt);
    end
  endtask

  task automatic test_flags();
    do_reset();
    out_ready = 1'b1; in_a = 4'b0111; in_b = 4'b0000;
    in_valid = 1'b1; in_op = 3'd1;
    tick();
    in_op = 3'd0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0111 || {out_zero, out_ones, out_parity} !== 3'b001) begin
      n_fail++; $display("FAIL flags_or: v=%b y=%b zop=%b required 1 0111 001", out_valid, out_y, {out_zero, out_ones, out_parity});
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_y !== 4'b0000 || {out_zero, out_ones, out_parity} !== 3'b100) begin
      n_fail++; $display("FAIL flags_and: v=%b y=%b zop=%b required 1 0000 100", out_valid, out_y, {out_zero, out_ones, out_parity});
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    bit acc_in;
    bit acc_out;
    logic [3:0] seen [4];
    do_reset();
    out_ready = 1'b0; in_op = 3'd7; in_b = 4'h0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_a = 4'(sent + 1);
      #1;
      acc_in = in_ready;
      tick();
      if (acc_in) sent++;
      if (c >= 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== 4'd1) begin
          n_fail++; $display("FAIL bp_hold c=%0d: v=%b y=%h required 1 1", c, out_valid, out_y);
        end
      end
    end
    n_checks++;
    if (sent !== 2 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accepted: sent=%0d in_ready=%b required 2 0", sent, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (sent < 4); in_a = 4'(sent + 1);
      #1;
      acc_in = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin seen[got] = out_y; got++; end
      tick();
      if (acc_in) sent++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL bp_drain_timeout: got %0d results required 4", got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen[i] !== 4'(i + 1)) begin
          n_fail++; $display("FAIL bp_order idx=%0d: got %h required %h", i, seen[i], 4'(i + 1));
        end
      end
    end
    n_checks++;
    if (out_cnt !== 16'd4) begin
      n_fail++; $display("FAIL bp_cnt: got %0d required 4", out_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    out_ready = 1'b0; in_op = 3'd7; in_b = 4'h0;
    in_valid = 1'b1; in_a = 4'd5;
    tick();
    in_a = 4'd6;
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = 4'(7 + c);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_y !== 4'(5 + c)) begin
        n_fail++; $display("FAIL simul c=%0d: in_ready=%b v=%b y=%0d required 1 1 %0d", c, in_ready, out_valid, out_y, 5 + c);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_y !== 4'(10 + c)) begin
        n_fail++; $display("FAIL simul_drain c=%0d: v=%b y=%0d required 1 %0d", c, out_valid, out_y, 10 + c);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_cnt !== 16'd7) begin
      n_fail++; $display("FAIL simul_end: v=%b cnt=%0d required 0 7", out_valid, out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_op = 3'd7; in_b = 4'h0;
    in_valid = 1'b1; in_a = 4'd12;
    tick();
    in_a = 4'd13;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || out_cnt !== 16'd0 || out_y !== 4'h0) begin
      n_fail++; $display("FAIL midrst_clear: v=%b cnt=%0d y=%h required 0 0 0", out_valid, out_cnt, out_y);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_stale c=%0d: out_valid=%b y=%h required 0", c, out_valid, out_y);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_a = 4'h0; in_b = 4'h0;
    test_reset();
    test_op_sweep();
    test_flags();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
